// File: rtl/io_link_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_link_if
//  Purpose  : Bundles the host-side FIFO handshake, the shared link bus to
//             the accelerator and the result/header outputs of io_link_ctrl.
//  Modports : master - controller view (drives ready/link/result signals)
//             slave  - environment view (drives host words, done, data_in)
//  Signals  : src_valid/src_data/src_last/src_ready - host load words
//             intrpt/cmd/done/data_out/data_oe/data_in - accelerator link
//             res_valid/res_data/res_eol/res_last     - result stream
//             hdr_t/hdr_n/hdr_err/busy                - header and status
//  Revision : 1.0 - initial release
// ============================================================================
interface io_link_if #(
  parameter int DATA_W = 32,
  parameter int T_W    = 4,
  parameter int N_W    = 6
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_last;
  logic              src_ready;
  logic              intrpt;
  logic              cmd;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_eol;
  logic              res_last;
  logic [T_W-1:0]    hdr_t;
  logic [N_W-1:0]    hdr_n;
  logic              hdr_err;
  logic              busy;

  modport master (
    input  src_valid, src_data, src_last, done, data_in,
    output src_ready, intrpt, cmd, data_out, data_oe,
           res_valid, res_data, res_eol, res_last,
           hdr_t, hdr_n, hdr_err, busy
  );

  modport slave (
    output src_valid, src_data, src_last, done, data_in,
    input  src_ready, intrpt, cmd, data_out, data_oe,
           res_valid, res_data, res_eol, res_last,
           hdr_t, hdr_n, hdr_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/io_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : io_link_ctrl
//  Purpose  : Host-to-accelerator link controller. Buffers host load words in
//             a TX FIFO, strobes them onto the shared link one LOAD command at
//             a time, then issues a PROCESS command, captures the result
//             header (T rows x N columns) and streams T*N result words back
//             with end-of-row / end-of-result markers.
//  Ports    : clk   - clock, all logic on the rising edge
//             reset - synchronous active-low reset
//             link  - io_link_if.master (handshake, link bus, results)
//  Note     : the interface instance must use the same DATA_W/T_W/N_W.
//  Revision : 1.0 - initial release
// ============================================================================
module io_link_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int T_W    = 4,
  parameter int N_W    = 6
) (
  input  logic       clk,
  input  logic       reset,
  io_link_if.master  link
);

  localparam int AW  = $clog2(DEPTH);
  localparam int E_W = T_W + N_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_PROC = 3'd3;
  localparam logic [2:0] S_RX   = 3'd4;

  // --------------------------------------------------------------------------
  // TX FIFO: entries are {last, data}
  // --------------------------------------------------------------------------
  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   head;

  logic [2:0]        state;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign push  = link.src_valid && !full;
  // LOAD is only entered with a non-empty FIFO and only left by this pop,
  // so the head is always valid here.
  assign pop   = (state == S_LOAD) && link.done;

  // Storage has no reset; emptiness is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {link.src_last, link.src_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and result path
  // --------------------------------------------------------------------------
  logic [T_W-1:0]    hdr_t_r;
  logic [N_W-1:0]    hdr_n_r;
  logic [N_W-1:0]    col_cnt;
  logic [E_W-1:0]    elem_cnt;
  logic [E_W-1:0]    total;
  logic [T_W-1:0]    in_t;
  logic [N_W-1:0]    in_n;
  logic              res_valid_r;
  logic [DATA_W-1:0] res_data_r;
  logic              res_eol_r;
  logic              res_last_r;
  logic              hdr_err_r;

  assign in_t  = link.data_in[T_W-1:0];
  assign in_n  = link.data_in[E_W-1:T_W];
  // Both operands widened to T_W+N_W so the product cannot overflow.
  assign total = E_W'(hdr_t_r) * E_W'(hdr_n_r);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      hdr_t_r     <= '0;
      hdr_n_r     <= '0;
      col_cnt     <= '0;
      elem_cnt    <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_eol_r   <= 1'b0;
      res_last_r  <= 1'b0;
      hdr_err_r   <= 1'b0;
    end else begin
      res_valid_r <= 1'b0;
      res_eol_r   <= 1'b0;
      res_last_r  <= 1'b0;
      hdr_err_r   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          if (link.done) state <= head[DATA_W] ? S_PROC : S_GAP;
        end
        S_GAP: begin
          // Wait for done to drop so a held acknowledge cannot pop twice.
          if (!link.done && !empty) state <= S_LOAD;
        end
        S_PROC: begin
          if (link.done) begin
            hdr_t_r  <= in_t;
            hdr_n_r  <= in_n;
            col_cnt  <= '0;
            elem_cnt <= '0;
            if (in_t == '0 || in_n == '0) begin
              hdr_err_r <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_RX;
            end
          end
        end
        S_RX: begin
          if (link.done) begin
            res_valid_r <= 1'b1;
            res_data_r  <= link.data_in;
            if (col_cnt == hdr_n_r - N_W'(1)) begin
              res_eol_r <= 1'b1;
              col_cnt   <= '0;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            elem_cnt <= elem_cnt + 1'b1;
            if (elem_cnt == total - E_W'(1)) begin
              res_last_r <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign link.src_ready = !full;
  assign link.intrpt    = (state == S_LOAD) || (state == S_PROC);
  assign link.cmd       = !((state == S_PROC) || (state == S_RX));
  assign link.data_oe   = (state == S_LOAD);
  assign link.data_out  = (state == S_LOAD) ? head[DATA_W-1:0] : '0;
  assign link.res_valid = res_valid_r;
  assign link.res_data  = res_data_r;
  assign link.res_eol   = res_eol_r;
  assign link.res_last  = res_last_r;
  assign link.hdr_t     = hdr_t_r;
  assign link.hdr_n     = hdr_n_r;
  assign link.hdr_err   = hdr_err_r;
  assign link.busy      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_io_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_link_ctrl
//  Purpose  : Self-checking bench for io_link_ctrl. Expected load words and
//             result words are queued when stimulus is driven and compared
//             when the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_link_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int T_W    = 4;
  localparam int N_W    = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  io_link_if #(.DATA_W(DATA_W), .T_W(T_W), .N_W(N_W)) link();

  io_link_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .T_W(T_W), .N_W(N_W)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0]   exp_load[$];   // {last, data}
  logic [DATA_W+1:0] exp_res[$];    // {eol, last, data}

  // Called at a negedge; presents one host word for one cycle.
  task automatic push_word(input logic [DATA_W-1:0] d, input logic l, input bit accepted);
    link.src_valid = 1'b1;
    link.src_data  = d;
    link.src_last  = l;
    if (accepted) exp_load.push_back({l, d});
    @(negedge clk);
    link.src_valid = 1'b0;
  endtask

  // Polls at negedges until the link shows a LOAD command.
  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (link.intrpt === 1'b1 && link.cmd === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({link.intrpt, link.cmd, link.data_oe, link.res_valid, link.res_eol, link.res_last,
         link.hdr_err, link.busy, link.src_ready} !== 9'b010_000_001) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", {link.intrpt, link.cmd, link.data_oe,
               link.res_valid, link.res_eol, link.res_last, link.hdr_err, link.busy,
               link.src_ready}, 9'b010_000_001);
    end
    checks++;
    if ({link.data_out, link.res_data, link.hdr_t, link.hdr_n} !== '0) begin
      errors++;
      $display("FAIL reset_buses: data_out=%h res_data=%h hdr_t=%0d hdr_n=%0d expected all 0",
               link.data_out, link.res_data, link.hdr_t, link.hdr_n);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Three load words; each LOAD is acknowledged for one cycle.
  task automatic test_load_seq;
    bit ok;
    logic [DATA_W:0] e;
    push_word(32'hAAAA_0001, 1'b0, 1'b1);
    push_word(32'hBBBB_0002, 1'b0, 1'b1);
    push_word(32'hCCCC_0003, 1'b1, 1'b1);
    for (int n = 0; n < 3; n++) begin
      wait_load(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL load_seq_timeout: no LOAD for word %0d expected within 20 cycles", n);
        return;
      end
      e = exp_load.pop_front();
      checks++;
      if (link.data_out !== e[DATA_W-1:0] || link.data_oe !== 1'b1) begin
        errors++;
        $display("FAIL load_seq_data: word %0d data_out=%h oe=%b expected %h oe=1",
                 n, link.data_out, link.data_oe, e[DATA_W-1:0]);
      end
      link.done = 1'b1;
      @(negedge clk);
      link.done = 1'b0;
      checks++;
      if ({link.intrpt, link.cmd} !== (e[DATA_W] ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL load_seq_pattern: after word %0d intrpt,cmd=%b expected %b",
                 n, {link.intrpt, link.cmd}, (e[DATA_W] ? 2'b10 : 2'b01));
      end
    end
  endtask

  // Header T=2,N=3 then six result words.
  task automatic test_result;
    logic [DATA_W+1:0] e;
    logic [DATA_W-1:0] d;
    link.data_in = 32'h0000_0032;
    link.done    = 1'b1;
    @(negedge clk);
    checks++;
    if (link.hdr_t !== 4'd2 || link.hdr_n !== 6'd3 || {link.intrpt, link.cmd} !== 2'b00) begin
      errors++;
      $display("FAIL result_header: hdr_t=%0d hdr_n=%0d intrpt,cmd=%b expected 2 3 00",
               link.hdr_t, link.hdr_n, {link.intrpt, link.cmd});
    end
    for (int k = 0; k < 6; k++) begin
      d = 32'hD000_0000 | 32'(k);
      link.data_in = d;
      link.done    = 1'b1;
      exp_res.push_back({(k % 3 == 2), (k == 5), d});
      @(negedge clk);
      e = exp_res.pop_front();
      checks++;
      if (link.res_valid !== 1'b1 || link.res_data !== e[DATA_W-1:0] ||
          link.res_eol !== e[DATA_W+1] || link.res_last !== e[DATA_W]) begin
        errors++;
        $display("FAIL result_word: word %0d valid=%b data=%h eol=%b last=%b expected 1 %h %b %b",
                 k, link.res_valid, link.res_data, link.res_eol, link.res_last,
                 e[DATA_W-1:0], e[DATA_W+1], e[DATA_W]);
      end
    end
    link.done = 1'b0;
    checks++;
    if (link.busy !== 1'b0) begin
      errors++;
      $display("FAIL result_busy: busy=%b expected 0 after last word", link.busy);
    end
    @(negedge clk);
    checks++;
    if (link.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL result_strobe: res_valid=%b expected 0 after stream", link.res_valid);
    end
  endtask

  // Fill FIFO, overflow attempt, pop with simultaneous push, zero-T header.
  task automatic test_fifo_full;
    bit ok;
    logic [DATA_W:0] e;
    for (int i = 0; i < DEPTH; i++) push_word(32'hF000_0000 | 32'(i), 1'b0, 1'b1);
    checks++;
    if (link.src_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_ready: src_ready=%b expected 0 after %0d pushes", link.src_ready, DEPTH);
    end
    push_word(32'hDEAD_BEEF, 1'b0, 1'b0);
    // First pop alone: occupancy drops to DEPTH-1.
    e = exp_load.pop_front();
    checks++;
    if (link.data_out !== e[DATA_W-1:0]) begin
      errors++;
      $display("FAIL fifo_head0: data_out=%h expected %h", link.data_out, e[DATA_W-1:0]);
    end
    link.done = 1'b1;
    @(negedge clk);
    link.done = 1'b0;
    checks++;
    if (link.src_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_after_pop: src_ready=%b expected 1", link.src_ready);
    end
    // Pop with a simultaneous push: occupancy stays DEPTH-1.
    wait_load(ok);
    e = exp_load.pop_front();
    checks++;
    if (!ok || link.data_out !== e[DATA_W-1:0]) begin
      errors++;
      $display("FAIL fifo_head1: load=%b data_out=%h expected load=1 %h", ok, link.data_out, e[DATA_W-1:0]);
    end
    link.done      = 1'b1;
    link.src_valid = 1'b1;
    link.src_data  = 32'h5A5A_0001;
    link.src_last  = 1'b0;
    exp_load.push_back({1'b0, 32'h5A5A_0001});
    @(negedge clk);
    link.done      = 1'b0;
    link.src_valid = 1'b0;
    checks++;
    if (link.src_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_simul_ready: src_ready=%b expected 1", link.src_ready);
    end
    push_word(32'h5A5A_0002, 1'b1, 1'b1);
    checks++;
    if (link.src_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_refull: src_ready=%b expected 0 (occupancy back at DEPTH)", link.src_ready);
    end
    for (int n = 0; n < DEPTH; n++) begin
      wait_load(ok);
      e = exp_load.pop_front();
      checks++;
      if (!ok || link.data_out !== e[DATA_W-1:0]) begin
        errors++;
        $display("FAIL fifo_drain: entry %0d load=%b data_out=%h expected load=1 %h",
                 n, ok, link.data_out, e[DATA_W-1:0]);
        if (!ok) return;
      end
      link.done = 1'b1;
      @(negedge clk);
      link.done = 1'b0;
    end
    checks++;
    if ({link.intrpt, link.cmd} !== 2'b10) begin
      errors++;
      $display("FAIL fifo_proc: intrpt,cmd=%b expected 10", {link.intrpt, link.cmd});
    end
    // Header T=0, N=5 is rejected.
    link.data_in = 32'h0000_0050;
    link.done    = 1'b1;
    @(negedge clk);
    link.done = 1'b0;
    checks++;
    if (link.hdr_err !== 1'b1 || link.busy !== 1'b0 || link.res_valid !== 1'b0 || link.hdr_n !== 6'd5) begin
      errors++;
      $display("FAIL hdr_err_pulse: hdr_err=%b busy=%b res_valid=%b hdr_n=%0d expected 1 0 0 5",
               link.hdr_err, link.busy, link.res_valid, link.hdr_n);
    end
    @(negedge clk);
    checks++;
    if (link.hdr_err !== 1'b0) begin
      errors++;
      $display("FAIL hdr_err_width: hdr_err=%b expected 0 one cycle later", link.hdr_err);
    end
    // done in IDLE is ignored.
    for (int i = 0; i < 3; i++) begin
      link.done = 1'b1;
      @(negedge clk);
      checks++;
      if (link.res_valid !== 1'b0 || link.busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_done: res_valid=%b busy=%b expected 0 0", link.res_valid, link.busy);
      end
    end
    link.done = 1'b0;
  endtask

  // Reset in the middle of a result stream.
  task automatic test_reset_in_rx;
    bit ok;
    logic [DATA_W:0] e;
    logic [DATA_W+1:0] r;
    push_word(32'h1234_5678, 1'b1, 1'b1);
    wait_load(ok);
    e = exp_load.pop_front();
    checks++;
    if (!ok || link.data_out !== e[DATA_W-1:0]) begin
      errors++;
      $display("FAIL rxrst_load: load=%b data_out=%h expected load=1 %h", ok, link.data_out, e[DATA_W-1:0]);
    end
    link.done = 1'b1;
    @(negedge clk);
    link.data_in = 32'h0000_0032;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      link.data_in = 32'hE000_0000 | 32'(k);
      exp_res.push_back({(k == 2), 1'b0, 32'hE000_0000 | 32'(k)});
      @(negedge clk);
      r = exp_res.pop_front();
      checks++;
      if (link.res_valid !== 1'b1 || link.res_data !== r[DATA_W-1:0] ||
          link.res_eol !== r[DATA_W+1] || link.res_last !== r[DATA_W]) begin
        errors++;
        $display("FAIL rxrst_word: word %0d valid=%b data=%h eol=%b last=%b expected 1 %h %b %b",
                 k, link.res_valid, link.res_data, link.res_eol, link.res_last,
                 r[DATA_W-1:0], r[DATA_W+1], r[DATA_W]);
      end
    end
    link.done = 1'b0;
    // A word pushed while in RX, then lost to reset.
    push_word(32'h0BAD_0BAD, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({link.intrpt, link.cmd, link.data_oe, link.res_valid, link.res_eol, link.res_last,
         link.hdr_err, link.busy, link.src_ready} !== 9'b010_000_001) begin
      errors++;
      $display("FAIL rxrst_flags: got %b expected %b", {link.intrpt, link.cmd, link.data_oe,
               link.res_valid, link.res_eol, link.res_last, link.hdr_err, link.busy,
               link.src_ready}, 9'b010_000_001);
    end
    checks++;
    if ({link.data_out, link.res_data, link.hdr_t, link.hdr_n} !== '0) begin
      errors++;
      $display("FAIL rxrst_buses: data_out=%h res_data=%h hdr_t=%0d hdr_n=%0d expected all 0",
               link.data_out, link.res_data, link.hdr_t, link.hdr_n);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      link.done    = 1'b1;
      link.data_in = 32'hE000_0010 | 32'(i);
      @(negedge clk);
      checks++;
      if (link.res_valid !== 1'b0 || link.intrpt !== 1'b0 || link.busy !== 1'b0) begin
        errors++;
        $display("FAIL rxrst_after: cycle %0d res_valid=%b intrpt=%b busy=%b expected 0 0 0",
                 i, link.res_valid, link.intrpt, link.busy);
      end
    end
    link.done = 1'b0;
    @(negedge clk);
  endtask

  // done held high across LOAD->GAP must not pop twice; then a 1x1 result.
  task automatic test_back_to_back;
    bit ok;
    logic [DATA_W:0] e;
    push_word(32'h7777_0000, 1'b0, 1'b1);
    push_word(32'h7777_0001, 1'b1, 1'b1);
    wait_load(ok);
    e = exp_load.pop_front();
    checks++;
    if (!ok || link.data_out !== e[DATA_W-1:0]) begin
      errors++;
      $display("FAIL held_w0: load=%b data_out=%h expected load=1 %h", ok, link.data_out, e[DATA_W-1:0]);
    end
    link.done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({link.intrpt, link.cmd, link.data_oe} !== 3'b010) begin
        errors++;
        $display("FAIL held_gap: cycle %0d intrpt,cmd,oe=%b expected 010", i,
                 {link.intrpt, link.cmd, link.data_oe});
      end
    end
    link.done = 1'b0;
    @(negedge clk);
    wait_load(ok);
    e = exp_load.pop_front();
    checks++;
    if (!ok || link.data_out !== e[DATA_W-1:0]) begin
      errors++;
      $display("FAIL held_w1: load=%b data_out=%h expected load=1 %h", ok, link.data_out, e[DATA_W-1:0]);
    end
    link.done = 1'b1;
    @(negedge clk);
    link.data_in = 32'h0000_0011;
    @(negedge clk);
    link.data_in = 32'h9999_0001;
    exp_res.push_back({1'b1, 1'b1, 32'h9999_0001});
    @(negedge clk);
    link.done = 1'b0;
    begin
      logic [DATA_W+1:0] r;
      r = exp_res.pop_front();
      checks++;
      if (link.res_valid !== 1'b1 || link.res_data !== r[DATA_W-1:0] || link.res_eol !== r[DATA_W+1] ||
          link.res_last !== r[DATA_W] || link.busy !== 1'b0) begin
        errors++;
        $display("FAIL single_result: valid=%b data=%h eol=%b last=%b busy=%b expected 1 %h %b %b 0",
                 link.res_valid, link.res_data, link.res_eol, link.res_last, link.busy,
                 r[DATA_W-1:0], r[DATA_W+1], r[DATA_W]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    link.src_valid = 1'b0;
    link.src_data  = '0;
    link.src_last  = 1'b0;
    link.done      = 1'b0;
    link.data_in   = '0;
    test_reset();
    test_load_seq();
    test_result();
    test_fifo_full();
    test_reset_in_rx();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
